// File: rtl/stack_text_scheduler_if.sv
// rtl/stack_text_scheduler_if.sv - stack read port and text buffer write port bundle
interface stack_text_scheduler_if #(
  parameter int DATA_W = 16,
  parameter int TXT_AW = 6,
  parameter int AW     = 3
);
  logic [AW-1:0]     stk_rd_addr;
  logic [DATA_W-1:0] stk_rd_data;
  logic              txt_we;
  logic [TXT_AW-1:0] txt_addr;
  logic [5:0]        txt_char;

  modport master (
    output stk_rd_addr, txt_we, txt_addr, txt_char,
    input  stk_rd_data
  );

  modport slave (
    input  stk_rd_addr, txt_we, txt_addr, txt_char,
    output stk_rd_data
  );
endinterface

// File: rtl/stack_text_scheduler.sv
// rtl/stack_text_scheduler.sv - per-frame stack-to-text refresh with double-dabble conversion
// Optional signed display with sign column: define STACK_TEXT_SIGNED_EN.
module stack_text_scheduler #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16,
  parameter int DIGITS = 5,
  parameter int TXT_AW = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_start,
  input  logic [3:0]                    stack_depth,
  stack_text_scheduler_if.master        bus,
  output logic                          busy,
  output logic                          done,
  output logic                          overrun
);
`ifdef STACK_TEXT_SIGNED_EN
  localparam int CHARS = DIGITS + 1;
  localparam bit SGN   = 1'b1;
`else
  localparam int CHARS = DIGITS;
  localparam bit SGN   = 1'b0;
`endif
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (CHARS > 1) ? $clog2(CHARS) : 1;
  localparam int NW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int BW = 4 * DIGITS;
  localparam logic [3:0] DEPTH_L = 4'(DEPTH);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, CONVERT, WRITE, DONE} state_t;

  state_t              state_q, state_d;
  logic [3:0]          entry_q, entry_d;
  logic [3:0]          depth_q, depth_d;
  logic [CW-1:0]       col_q, col_d;
  logic [NW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   bin_q, bin_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic                sign_q, sign_d;
  logic                seen_q, seen_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic                we_q, we_d;
  logic [TXT_AW-1:0]   taddr_q, taddr_d;
  logic [5:0]          char_q, char_d;
  logic                done_q, done_d;
  logic                ovr_q, ovr_d;

  logic [3:0]              entry_nx;
  logic [3:0]              dep_clamp;
  logic [3:0]              digit;
  logic [BW-1:0]           bcd_adj;
  logic [BW+DATA_W-1:0]    shifted;
  logic                    blank_row;
  logic [DATA_W-1:0]       rd_word;
  int                      didx;

  always_comb begin
    state_d   = state_q;
    entry_d   = entry_q;
    depth_d   = depth_q;
    col_d     = col_q;
    cnt_d     = cnt_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    sign_d    = sign_q;
    seen_d    = seen_q;
    addr_d    = addr_q;
    we_d      = 1'b0;
    taddr_d   = taddr_q;
    char_d    = char_q;
    done_d    = 1'b0;
    ovr_d     = ovr_q;
    entry_nx  = entry_q + 4'd1;
    dep_clamp = (stack_depth > DEPTH_L) ? DEPTH_L : stack_depth;
    digit     = 4'd0;
    bcd_adj   = bcd_q;
    shifted   = '0;
    blank_row = (entry_q >= depth_q);
    rd_word   = bus.stk_rd_data;
    didx      = 0;

    if (frame_start && state_q != IDLE) ovr_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          depth_d = dep_clamp;
          entry_d = 4'd0;
          col_d   = '0;
          seen_d  = 1'b0;
          addr_d  = '0;
          state_d = (dep_clamp == 4'd0) ? WRITE : FETCH;
        end
      end
      FETCH: state_d = WAIT;
      WAIT: begin
`ifdef STACK_TEXT_SIGNED_EN
        sign_d = rd_word[DATA_W-1];
        bin_d  = rd_word[DATA_W-1] ? (~rd_word + {{(DATA_W-1){1'b0}}, 1'b1}) : rd_word;
`else
        sign_d = 1'b0;
        bin_d  = rd_word;
`endif
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = CONVERT;
      end
      CONVERT: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        shifted        = {bcd_adj, bin_q} << 1;
        {bcd_d, bin_d} = shifted;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == NW'(DATA_W - 1)) begin
          state_d = WRITE;
          col_d   = '0;
          seen_d  = 1'b0;
        end
      end
      WRITE: begin
        we_d    = 1'b1;
        taddr_d = TXT_AW'(int'(entry_q) * CHARS + int'(col_q));
        if (blank_row) begin
          char_d = 6'h00;
        end else if (SGN && col_q == '0) begin
          char_d = sign_q ? 6'h2D : 6'h00;
        end else begin
          didx  = CHARS - 1 - int'(col_q);
          digit = bcd_q[4*didx +: 4];
          // Last column always shows a digit so a zero value is visible.
          if (digit != 4'd0 || seen_q || col_q == CW'(CHARS - 1)) begin
            char_d = {2'b11, digit};
            seen_d = 1'b1;
          end else begin
            char_d = 6'h00;
          end
        end
        col_d = col_q + 1'b1;
        if (col_q == CW'(CHARS - 1)) begin
          col_d   = '0;
          seen_d  = 1'b0;
          entry_d = entry_nx;
          if (entry_nx == DEPTH_L) begin
            state_d = DONE;
          end else if (entry_nx < depth_q) begin
            addr_d  = AW'(entry_nx);
            state_d = FETCH;
          end else begin
            state_d = WRITE;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      entry_q <= '0;
      depth_q <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      sign_q  <= 1'b0;
      seen_q  <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      taddr_q <= '0;
      char_q  <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      depth_q <= depth_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      sign_q  <= sign_d;
      seen_q  <= seen_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      taddr_q <= taddr_d;
      char_q  <= char_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.stk_rd_addr = addr_q;
  assign bus.txt_we      = we_q;
  assign bus.txt_addr    = taddr_q;
  assign bus.txt_char    = char_q;
  assign busy            = (state_q != IDLE);
  assign done            = done_q;
  assign overrun         = ovr_q;
endmodule

// File: tb/tb_stack_text_scheduler.sv
// tb/tb_stack_text_scheduler.sv - directed and randomized checks against a decimal-text reference model
module tb_stack_text_scheduler;
  localparam int DEPTH  = 8;
  localparam int DATA_W = 16;
  localparam int DIGITS = 5;
`ifdef STACK_TEXT_SIGNED_EN
  localparam int CHARS = DIGITS + 1;
`else
  localparam int CHARS = DIGITS;
`endif
  localparam int NTXT = DEPTH * CHARS;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_start = 1'b0;
  logic [3:0] stack_depth = 4'd0;
  logic       busy, done, overrun;

  stack_text_scheduler_if bus ();

  stack_text_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .stack_depth (stack_depth),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [DEPTH];
  always @(posedge clk) bus.stk_rd_data <= mem[bus.stk_rd_addr];

  int errors, checks;
  int frame_id, wr_n, order_err;
  int txt [64];
  int stamp [64];
  int rd_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp_depth(input int sd);
    return (sd > DEPTH) ? DEPTH : sd;
  endfunction

  function automatic int exp_done(input int d);
    return 1 + d * (2 + DATA_W + CHARS) + (DEPTH - d) * CHARS;
  endfunction

  // Decimal text of an entry, computed by place value rather than BCD.
  function automatic int exp_char(input int e, input int c, input int d);
    int v, p, dc;
    if (e >= d) return 0;
    v  = int'(mem[e]);
    dc = c;
`ifdef STACK_TEXT_SIGNED_EN
    if (mem[e][15]) v = 65536 - v;
    if (c == 0) return mem[e][15] ? 'h2D : 0;
    dc = c - 1;
`endif
    p = 1;
    for (int k = 0; k < DIGITS - 1 - dc; k++) p = p * 10;
    if (v < p && dc != DIGITS - 1) return 0;
    return 'h30 + (v / p) % 10;
  endfunction

  task automatic run_frame(input int sd, input int extra_at, input int rst_at, output int dcyc);
    int cyc, prev;
    frame_id++;
    wr_n = 0;
    order_err = 0;
    rd_q.delete();
    prev = -1;
    dcyc = -1;
    stack_depth = 4'(sd);
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    cyc = 0;
    while (cyc < 400) begin
      if (rst_at > 0 && cyc == rst_at) begin
        chk("rst_txt_we", bus.txt_we, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        dcyc = -2;
        break;
      end
      if (bus.txt_we) begin
        if (int'(bus.txt_addr) != wr_n) order_err++;
        txt[bus.txt_addr] = int'(bus.txt_char);
        stamp[bus.txt_addr] = frame_id;
        wr_n++;
      end
      if (int'(bus.stk_rd_addr) != prev) begin
        rd_q.push_back(int'(bus.stk_rd_addr));
        prev = int'(bus.stk_rd_addr);
      end
      if (done) begin
        dcyc = cyc;
        chk("busy_after_done", busy, 0);
        break;
      end
      if (cyc == 3) stack_depth = 4'($urandom_range(0, 15));
      frame_start = (cyc + 1 == extra_at);
      reset = (cyc + 1 == rst_at);
      @(negedge clk);
      cyc++;
    end
    frame_start = 1'b0;
  endtask

  task automatic check_frame(input int sd, input int dcyc);
    int d;
    d = clamp_depth(sd);
    chk("done_cycle", dcyc, exp_done(d));
    chk("write_count", wr_n, NTXT);
    chk("write_order", order_err, 0);
    for (int a = 0; a < NTXT; a++) begin
      chk("txt_written", stamp[a], frame_id);
      chk("txt_char", txt[a], exp_char(a / CHARS, a % CHARS, d));
    end
  endtask

  initial begin
    int dc, sd;
    errors = 0;
    checks = 0;
    frame_id = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'd0;
    for (int i = 0; i < 64; i++) begin
      txt[i] = -1;
      stamp[i] = -1;
    end
    repeat (3) @(negedge clk);
    chk("rst_txt_we0", bus.txt_we, 0);
    chk("rst_txt_addr", bus.txt_addr, 0);
    chk("rst_txt_char", bus.txt_char, 0);
    chk("rst_rd_addr", bus.stk_rd_addr, 0);
    chk("rst_busy0", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    reset = 1'b0;
    @(negedge clk);

    run_frame(0, -1, -1, dc);
    check_frame(0, dc);

    mem[0] = 16'd1234;
    run_frame(1, -1, -1, dc);
    check_frame(1, dc);

    mem[0] = 16'd0;
    mem[1] = 16'd65535;
    run_frame(2, -1, -1, dc);
    check_frame(2, dc);
    chk("overrun_clear", overrun, 0);

    for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
    run_frame(8, 50, -1, dc);
    check_frame(8, dc);
    chk("overrun_set", overrun, 1);
    chk("rd_seq_len", rd_q.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < rd_q.size(); i++) chk("rd_seq", rd_q[i], i);

    run_frame(8, -1, 75, dc);
    chk("rst_path", dc, -2);
    @(negedge clk);
    chk("overrun_after_rst", overrun, 0);
    run_frame(8, -1, -1, dc);
    check_frame(8, dc);
    chk("overrun_sticky_idle", overrun, 0);

    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 99)) : 16'($urandom);
      sd = $urandom_range(0, 15);
      run_frame(sd, -1, -1, dc);
      check_frame(sd, dc);
    end

`ifdef STACK_TEXT_SIGNED_EN
    begin
      int e0 [6];
      int e1 [6];
      e0 = '{'h2D, 'h33, 'h32, 'h37, 'h36, 'h38};
      e1 = '{'h2D, 'h00, 'h00, 'h00, 'h00, 'h31};
      mem[0] = 16'h8000;
      mem[1] = 16'hFFFF;
      run_frame(2, -1, -1, dc);
      chk("signed_done", dc, exp_done(2));
      for (int c = 0; c < 6; c++) begin
        chk("signed_min", txt[c], e0[c]);
        chk("signed_m1", txt[6 + c], e1[c]);
      end
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
